// File: rtl/io_timer.sv
// RRIOT interval timer: 8-bit down-counter behind a 1/8/64/1024 prescaler.
// Owns bus offsets with A[2]=1 and drives the active-low irq_n line.
module io_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       we_n,
  input  logic [3:0] A,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  output logic       OE,
  output logic       irq_n
);

  logic [7:0] count_q, count_d;
  logic [9:0] pre_q, pre_d;
  logic [1:0] div_sel_q, div_sel_d;
  logic       irq_en_q, irq_en_d;
  logic       irq_flag_q, irq_flag_d;
  logic       fast_q, fast_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic       sel;
  logic       wr;
  logic       rd_tmr;
  logic       rd_flg;
  logic [9:0] lim;
  logic       tick;
  logic       under;

  assign sel    = enable & A[2];
  assign wr     = sel & ~we_n;
  assign rd_tmr = sel & we_n & ~A[0];
  assign rd_flg = sel & we_n & A[0];

  always_comb begin
    lim = 10'd0;
    unique case (div_sel_q)
      2'b00: lim = 10'd0;
      2'b01: lim = 10'd7;
      2'b10: lim = 10'd63;
      2'b11: lim = 10'd1023;
      default: lim = 10'd0;
    endcase
  end

  assign tick  = fast_q | (pre_q == lim);
  assign under = tick & (count_q == 8'h00);

  always_comb begin
    count_d    = count_q;
    pre_d      = pre_q;
    div_sel_d  = div_sel_q;
    irq_en_d   = irq_en_q;
    irq_flag_d = irq_flag_q;
    fast_d     = fast_q;
    rd_data_d  = rd_data_q;

    if (wr) begin
      // A write restarts the timer and overrides any tick on this edge
      count_d    = DI;
      div_sel_d  = A[1:0];
      irq_en_d   = A[3];
      pre_d      = 10'd0;
      fast_d     = 1'b0;
      irq_flag_d = 1'b0;
    end else begin
      if (!fast_q) begin
        pre_d = tick ? 10'd0 : pre_q + 10'd1;
      end
      if (tick) begin
        count_d = count_q - 8'd1;
      end
      if (rd_tmr) begin
        rd_data_d  = count_q;
        irq_en_d   = A[3];
        irq_flag_d = 1'b0;
      end
      if (rd_flg) begin
        rd_data_d = {irq_flag_q, 7'b0};
      end
      // Underflow after the read clear so a coincident set wins
      if (under) begin
        irq_flag_d = 1'b1;
        fast_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 8'h00;
      pre_q      <= 10'd0;
      div_sel_q  <= 2'b00;
      irq_en_q   <= 1'b0;
      irq_flag_q <= 1'b0;
      fast_q     <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      count_q    <= count_d;
      pre_q      <= pre_d;
      div_sel_q  <= div_sel_d;
      irq_en_q   <= irq_en_d;
      irq_flag_q <= irq_flag_d;
      fast_q     <= fast_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign OE    = sel & we_n;
  assign DO    = OE ? rd_data_q : 8'h00;
  assign irq_n = ~(irq_flag_q & irq_en_q);

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: vector table for div /1 and port-space
// isolation, hand sequences for prescale, wrap, collisions and reset.
module tb_io_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       we_n;
  logic [3:0] A;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       OE;
  logic       irq_n;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       we_n;
    logic [3:0] a;
    logic [7:0] di;
    logic [7:0] exp_do;
    logic       exp_oe;
    logic       exp_irqn;
  } vec_t;

  vec_t vec [12];

  io_timer dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .we_n   (we_n),
    .A      (A),
    .DI     (DI),
    .DO     (DO),
    .OE     (OE),
    .irq_n  (irq_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic w, input logic [3:0] a,
                      input logic [7:0] d);
    enable = e;
    we_n   = w;
    A      = a;
    DI     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'h0, 8'h00);
  endtask

  initial begin
    vec[0]  = '{1'b1, 1'b0, 4'hC, 8'h03, 8'h00, 1'b0, 1'b1};
    vec[1]  = '{1'b1, 1'b1, 4'hC, 8'h00, 8'h03, 1'b1, 1'b1};
    vec[2]  = '{1'b1, 1'b1, 4'hC, 8'h00, 8'h02, 1'b1, 1'b1};
    vec[3]  = '{1'b1, 1'b1, 4'hC, 8'h00, 8'h01, 1'b1, 1'b1};
    vec[4]  = '{1'b1, 1'b1, 4'hC, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b1, 4'hC, 8'h00, 8'hFE, 1'b1, 1'b1};
    vec[7]  = '{1'b1, 1'b1, 4'hD, 8'h00, 8'h00, 1'b1, 1'b1};
    vec[8]  = '{1'b1, 1'b0, 4'h0, 8'hAA, 8'h00, 1'b0, 1'b1};
    vec[9]  = '{1'b1, 1'b1, 4'h8, 8'h00, 8'h00, 1'b0, 1'b1};
    vec[10] = '{1'b1, 1'b1, 4'h4, 8'h00, 8'hFA, 1'b1, 1'b1};
    vec[11] = '{1'b1, 1'b1, 4'h4, 8'h00, 8'hF9, 1'b1, 1'b1};

    // Reset and free-run underflow
    rst = 1'b1; enable = 1'b0; we_n = 1'b1; A = 4'h0; DI = 8'h00;
    #12;
    check("rst_irq_n", {7'b0, irq_n}, 8'h01);
    check("rst_oe", {7'b0, OE}, 8'h00);
    check("rst_do", DO, 8'h00);
    rst = 1'b0;
    idle(1);
    check("free_irq_n", {7'b0, irq_n}, 8'h01);
    step(1'b1, 1'b1, 4'h5, 8'h00);
    check("free_flag", DO, 8'h80);
    check("free_flag_oe", {7'b0, OE}, 8'h01);

    // Div /1 with IRQ, then port-space isolation
    for (int i = 0; i < 12; i++) begin
      step(vec[i].en, vec[i].we_n, vec[i].a, vec[i].di);
      check($sformatf("vec%0d_do", i), DO, vec[i].exp_do);
      check($sformatf("vec%0d_oe", i), {7'b0, OE}, {7'b0, vec[i].exp_oe});
      check($sformatf("vec%0d_irqn", i), {7'b0, irq_n},
            {7'b0, vec[i].exp_irqn});
    end

    // Div /8 without IRQ
    step(1'b1, 1'b0, 4'h5, 8'h02);
    idle(7);
    step(1'b1, 1'b1, 4'h4, 8'h00);
    check("div8_e8", DO, 8'h02);
    idle(7);
    step(1'b1, 1'b1, 4'h4, 8'h00);
    check("div8_e16", DO, 8'h01);
    idle(8);
    check("div8_irqn", {7'b0, irq_n}, 8'h01);
    step(1'b1, 1'b1, 4'h5, 8'h00);
    check("div8_flag", DO, 8'h80);
    step(1'b1, 1'b1, 4'h4, 8'h00);
    check("div8_e26", DO, 8'hFE);

    // Timer read clears flag; flag returns on fast-mode wrap
    step(1'b1, 1'b1, 4'hC, 8'h00);
    check("rdclr_do", DO, 8'hFD);
    check("rdclr_irqn", {7'b0, irq_n}, 8'h01);
    step(1'b1, 1'b1, 4'hD, 8'h00);
    check("rdclr_flag", DO, 8'h00);
    idle(251);
    check("wrap_pre_irqn", {7'b0, irq_n}, 8'h01);
    idle(1);
    check("wrap_irqn", {7'b0, irq_n}, 8'h00);

    // Write on the underflow edge wins, div /1024
    step(1'b1, 1'b0, 4'hC, 8'h02);
    idle(2);
    step(1'b1, 1'b0, 4'hF, 8'h10);
    check("coll_irqn", {7'b0, irq_n}, 8'h01);
    idle(1023);
    step(1'b1, 1'b1, 4'hC, 8'h00);
    check("div1024_e1024", DO, 8'h10);
    step(1'b1, 1'b1, 4'hC, 8'h00);
    check("div1024_e1025", DO, 8'h0F);
    step(1'b1, 1'b1, 4'hD, 8'h00);
    check("coll_flag", DO, 8'h00);

    // Timer read on the underflow edge leaves the flag set
    step(1'b1, 1'b0, 4'hC, 8'h01);
    idle(1);
    step(1'b1, 1'b1, 4'hC, 8'h00);
    check("rdund_do", DO, 8'h00);
    check("rdund_irqn", {7'b0, irq_n}, 8'h00);
    step(1'b1, 1'b1, 4'hD, 8'h00);
    check("rdund_flag", DO, 8'h80);

    // Asynchronous reset mid-count
    #2;
    rst = 1'b1;
    #1;
    check("arst_irqn", {7'b0, irq_n}, 8'h01);
    check("arst_do", DO, 8'h00);
    enable = 1'b0;
    #1;
    check("arst_oe", {7'b0, OE}, 8'h00);
    rst = 1'b0;
    idle(1);
    check("arst_run_irqn", {7'b0, irq_n}, 8'h01);
    step(1'b1, 1'b1, 4'h5, 8'h00);
    check("arst_run_flag", DO, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
